// File: rtl/lc3b_types.sv
// Shared types for the L1 cache controller: FSM state encoding and mux selects.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } lc3b_cache_state;

  // Datapath data-in mux select
  localparam logic SEL_PMEM_DATA = 1'b0;
  localparam logic SEL_CPU_DATA  = 1'b1;

  // Physical memory address mux select
  localparam logic SEL_CPU_ADDR  = 1'b0;
  localparam logic SEL_WB_ADDR   = 1'b1;

endpackage

// File: rtl/cache_control_sat_counter.sv
// Saturating up-counter used for the optional performance counters.
module sat_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [width-1:0] count
);

  logic [width-1:0] count_q, count_d;

  // Next count: step by one unless already at the all-ones ceiling
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {width{1'b1}}))
      count_d = count_q + 1'b1;
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative, write-back, write-allocate L1.
// Optional performance counters are built only when CACHE_CTRL_PERF_EN is defined.
module cache_control
  import lc3b_types::*;
#(
  parameter int PERF_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            mem_byte_enable,
  output logic                  mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  input  logic                  pmem_resp,
  input  logic                  hit,
  input  logic                  way_select,
  input  logic                  lru_out,
  input  logic                  dirty1_out,
  input  logic                  dirty2_out,
  output logic                  eviction,
  output logic                  load_tag1,
  output logic                  load_tag2,
  output logic                  load_valid1,
  output logic                  load_valid2,
  output logic                  load_data1,
  output logic                  load_data2,
  output logic                  load_dirty1,
  output logic                  load_dirty2,
  output logic                  load_lru,
  output logic                  valid1_in,
  output logic                  valid2_in,
  output logic                  dirty1_in,
  output logic                  dirty2_in,
  output logic                  lru_in,
  output logic                  datain_sel,
  output logic                  pmem_addr_sel,
  output logic [PERF_WIDTH-1:0] hit_count,
  output logic [PERF_WIDTH-1:0] miss_count,
  output logic [PERF_WIDTH-1:0] wb_count
);

  lc3b_cache_state state_q, state_d;
  logic req, wr, victim_dirty;

  // Byte lanes are merged in the datapath; the controller does not need them
  logic unused_be;
  assign unused_be = ^mem_byte_enable;

  // A write wins over a simultaneous read; nothing is accepted while in reset
  assign req          = (mem_read | mem_write) & ~reset;
  assign wr           = mem_write;
  assign victim_dirty = lru_out ? dirty2_out : dirty1_out;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and all array/memory strobes
  always_comb begin
    state_d       = state_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    eviction      = 1'b0;
    load_tag1     = 1'b0;
    load_tag2     = 1'b0;
    load_valid1   = 1'b0;
    load_valid2   = 1'b0;
    load_data1    = 1'b0;
    load_data2    = 1'b0;
    load_dirty1   = 1'b0;
    load_dirty2   = 1'b0;
    load_lru      = 1'b0;
    valid1_in     = 1'b0;
    valid2_in     = 1'b0;
    dirty1_in     = 1'b0;
    dirty2_in     = 1'b0;
    lru_in        = 1'b0;
    datain_sel    = SEL_PMEM_DATA;
    pmem_addr_sel = SEL_CPU_ADDR;
    unique case (state_q)
      IDLE: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          load_lru = 1'b1;
          lru_in   = ~way_select;
          if (wr) begin
            datain_sel = SEL_CPU_DATA;
            if (way_select) begin
              load_data2  = 1'b1;
              load_dirty2 = 1'b1;
              dirty2_in   = 1'b1;
            end else begin
              load_data1  = 1'b1;
              load_dirty1 = 1'b1;
              dirty1_in   = 1'b1;
            end
          end
        end else if (req) begin
          eviction = 1'b1;
          state_d  = victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        eviction      = 1'b1;
        pmem_addr_sel = SEL_WB_ADDR;
        pmem_write    = 1'b1;
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        eviction  = 1'b1;
        pmem_read = 1'b1;
        if (pmem_resp) begin
          // Fill the victim (LRU) way with a clean, valid line
          if (lru_out) begin
            load_data2  = 1'b1;
            load_tag2   = 1'b1;
            load_valid2 = 1'b1;
            valid2_in   = 1'b1;
            load_dirty2 = 1'b1;
          end else begin
            load_data1  = 1'b1;
            load_tag1   = 1'b1;
            load_valid1 = 1'b1;
            valid1_in   = 1'b1;
            load_dirty1 = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_CTRL_PERF_EN
  logic miss_inc, wb_inc;
  assign miss_inc = (state_q == IDLE) && (state_d != IDLE);
  assign wb_inc   = (state_q == WRITEBACK) && pmem_resp;

  sat_counter #(.width(PERF_WIDTH)) u_hit_cnt (
    .clk(clk), .reset(reset), .inc(mem_resp), .count(hit_count));
  sat_counter #(.width(PERF_WIDTH)) u_miss_cnt (
    .clk(clk), .reset(reset), .inc(miss_inc), .count(miss_count));
  sat_counter #(.width(PERF_WIDTH)) u_wb_cnt (
    .clk(clk), .reset(reset), .inc(wb_inc), .count(wb_count));
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control with an expected-output scoreboard.
module tb_cache_control;

  localparam int PW = 4;
`ifdef CACHE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic mem_read = 0, mem_write = 0, pmem_resp = 0, hit = 0, way_select = 0;
  logic lru_out = 0, dirty1_out = 0, dirty2_out = 0;
  logic [1:0] mem_byte_enable = 2'b11;
  logic mem_resp, pmem_read, pmem_write, eviction;
  logic load_tag1, load_tag2, load_valid1, load_valid2, load_data1, load_data2;
  logic load_dirty1, load_dirty2, load_lru;
  logic valid1_in, valid2_in, dirty1_in, dirty2_in, lru_in, datain_sel, pmem_addr_sel;
  logic [PW-1:0] hit_count, miss_count, wb_count;

  cache_control #(.PERF_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .hit(hit), .way_select(way_select), .lru_out(lru_out),
    .dirty1_out(dirty1_out), .dirty2_out(dirty2_out), .eviction(eviction),
    .load_tag1(load_tag1), .load_tag2(load_tag2),
    .load_valid1(load_valid1), .load_valid2(load_valid2),
    .load_data1(load_data1), .load_data2(load_data2),
    .load_dirty1(load_dirty1), .load_dirty2(load_dirty2), .load_lru(load_lru),
    .valid1_in(valid1_in), .valid2_in(valid2_in),
    .dirty1_in(dirty1_in), .dirty2_in(dirty2_in), .lru_in(lru_in),
    .datain_sel(datain_sel), .pmem_addr_sel(pmem_addr_sel),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count));

  always #5 clk = ~clk;

  // Output vector bit masks
  localparam logic [19:0] RESP = 20'h80000, PR   = 20'h40000, PWR  = 20'h20000;
  localparam logic [19:0] EV   = 20'h10000, LT1  = 20'h08000, LT2  = 20'h04000;
  localparam logic [19:0] LV1  = 20'h02000, LV2  = 20'h01000, LD1  = 20'h00800;
  localparam logic [19:0] LD2  = 20'h00400, LDD1 = 20'h00200, LDD2 = 20'h00100;
  localparam logic [19:0] LLRU = 20'h00080, V1I  = 20'h00040, V2I  = 20'h00020;
  localparam logic [19:0] D1I  = 20'h00010, D2I  = 20'h00008, LRUI = 20'h00004;
  localparam logic [19:0] DSEL = 20'h00002, ASEL = 20'h00001;
  localparam logic [19:0] NONE = 20'h00000;

  wire [19:0] obs = {mem_resp, pmem_read, pmem_write, eviction, load_tag1, load_tag2,
                     load_valid1, load_valid2, load_data1, load_data2, load_dirty1,
                     load_dirty2, load_lru, valid1_in, valid2_in, dirty1_in, dirty2_in,
                     lru_in, datain_sel, pmem_addr_sel};

  int n_assert = 0, n_fail = 0;
  logic [19:0] exp_q[$];
  string       tag_q[$];

  task automatic push(input logic [19:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    logic [19:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %05h expected %05h", t, obs, e);
    end
  endtask

  // Expect e this cycle (sampled mid-cycle), then advance to just after next edge
  task automatic step(input logic [19:0] e, input string tag);
    push(e, tag);
    #4;
    pop_check();
    @(posedge clk);
    #1;
  endtask

  task automatic cnt_check(input logic [PW-1:0] o, input logic [PW-1:0] e, input string tag);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  initial begin
    // Reset state
    #2;
    push(NONE, "reset_outputs"); pop_check();
    cnt_check(hit_count, '0, "reset_hit_count");
    cnt_check(miss_count, '0, "reset_miss_count");
    @(posedge clk); #1;
    reset = 0;
    step(NONE, "idle_no_req");

    // Read miss, clean victim in way 0, pmem latency 3
    mem_read = 1; hit = 0; lru_out = 0; dirty1_out = 0; way_select = 0;
    step(EV, "clean_miss_idle");
    step(PR | EV, "alloc_c1");
    step(PR | EV, "alloc_c2");
    pmem_resp = 1;
    step(PR | EV | LT1 | LV1 | LD1 | LDD1 | V1I, "alloc_fill_w0");
    pmem_resp = 0; hit = 1;
    step(RESP | LLRU | LRUI, "retry_read_hit");
    mem_read = 0;
    step(NONE, "idle_after_read");

    // Write hit in way 1
    mem_write = 1; hit = 1; way_select = 1;
    step(RESP | LD2 | LDD2 | D2I | LLRU | DSEL, "write_hit_w1");
    mem_write = 0; hit = 0;

    // Dirty miss: victim way 1
    mem_read = 1; lru_out = 1; dirty2_out = 1; way_select = 1;
    step(EV, "dirty_miss_idle");
    step(PWR | EV | ASEL, "wb_c1");
    step(PWR | EV | ASEL, "wb_c2");
    pmem_resp = 1;
    step(PWR | EV | ASEL, "wb_resp");
    pmem_resp = 0;
    step(PR | EV, "alloc2_c1");
    pmem_resp = 1;
    step(PR | EV | LT2 | LV2 | LD2 | LDD2 | V2I, "alloc_fill_w1");
    pmem_resp = 0; hit = 1; dirty2_out = 0;
    step(RESP | LLRU, "retry_dirty_hit");
    mem_read = 0; hit = 0;
    cnt_check(hit_count, PERF ? PW'(3) : PW'(0), "hit_count_3");
    cnt_check(miss_count, PERF ? PW'(2) : PW'(0), "miss_count_2");
    cnt_check(wb_count, PERF ? PW'(1) : PW'(0), "wb_count_1");

    // Stray pmem_resp in IDLE is ignored
    pmem_resp = 1;
    step(NONE, "stray_resp");
    pmem_resp = 0;
    step(NONE, "stray_resp_after");

    // Simultaneous read and write is handled as a write (way 0 hit)
    mem_read = 1; mem_write = 1; hit = 1; way_select = 0;
    step(RESP | LD1 | LDD1 | D1I | LLRU | LRUI | DSEL, "rd_wr_as_write");
    mem_read = 0; mem_write = 0; hit = 0;

    // Async reset mid-ALLOCATE: strobes drop at once, no fill
    mem_read = 1; lru_out = 0; dirty1_out = 0;
    step(EV, "rst_miss_idle");
    step(PR | EV, "rst_alloc_c1");
    reset = 1; pmem_resp = 1;
    #1;
    push(NONE, "reset_mid_alloc"); pop_check();
    cnt_check(hit_count, '0, "rst_hit_count");
    cnt_check(miss_count, '0, "rst_miss_count");
    cnt_check(wb_count, '0, "rst_wb_count");
    @(posedge clk); #1;
    reset = 0; pmem_resp = 0; mem_read = 0;
    step(NONE, "idle_after_reset");

    // Saturation: 20 back-to-back read hits
    mem_read = 1; hit = 1; way_select = 1;
    for (int i = 0; i < 20; i++) step(RESP | LLRU, "sat_hit");
    mem_read = 0; hit = 0;
    cnt_check(hit_count, PERF ? PW'(15) : PW'(0), "hit_count_sat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
